// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port synchronous data memory between the LSU (port 0) and
// the debug/loader path (port 1), with bounded locks. ARB_ROUND_ROBIN_EN selects round-robin contention.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p0_valid,
    output logic                p0_ready,
    input  logic                p0_we,
    input  logic                p0_lock,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic [DATA_W-1:0]   p0_wdata,
    input  logic [DATA_W/8-1:0] p0_wmask,
    output logic                p0_rvalid,
    output logic [DATA_W-1:0]   p0_rdata,
    input  logic                p1_valid,
    output logic                p1_ready,
    input  logic                p1_we,
    input  logic                p1_lock,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [DATA_W-1:0]   p1_wdata,
    input  logic [DATA_W/8-1:0] p1_wmask,
    output logic                p1_rvalid,
    output logic [DATA_W-1:0]   p1_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                lock_timeout
);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             prio_q, prio_d;
    logic             vld0_p1, vld1_p1;
    logic             gnt0, gnt1;
    logic             timeout;

    assign timeout = (state_q != IDLE) && (lock_cnt_q == CNT_W'(MAX_LOCK));

    // Grant depends only on valid, state and priority; reset forces every grant off.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state_q)
            LOCK0:   gnt0 = p0_valid;
            LOCK1:   gnt1 = p1_valid;
            default: begin
                if (p0_valid && p1_valid) begin
                    gnt0 = !prio_q;
                    gnt1 = prio_q;
                end else begin
                    gnt0 = p0_valid;
                    gnt1 = p1_valid;
                end
            end
        endcase
        if (!rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        prio_d     = prio_q;
        case (state_q)
            IDLE: begin
                if (gnt0 && p0_lock) begin
                    state_d    = LOCK0;
                    lock_cnt_d = CNT_W'(1);
                end else if (gnt1 && p1_lock) begin
                    state_d    = LOCK1;
                    lock_cnt_d = CNT_W'(1);
                end
            end
            LOCK0: begin
                if (timeout || (gnt0 && !p0_lock)) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            LOCK1: begin
                if (timeout || (gnt1 && !p1_lock)) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        endcase
`ifdef ARB_ROUND_ROBIN_EN
        if (timeout)
            prio_d = (state_q == LOCK0);
        else if (gnt0)
            prio_d = 1'b1;
        else if (gnt1)
            prio_d = 1'b0;
`else
        // Port 1 priority after a port-0 timeout is one-shot: the next contention consumes it.
        if (timeout)
            prio_d = (state_q == LOCK0);
        else if (state_q == IDLE && p0_valid && p1_valid)
            prio_d = 1'b0;
`endif
    end

    // Stage p1: arbitration state and read-owner flags for the data returned next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            prio_q     <= 1'b0;
            vld0_p1    <= 1'b0;
            vld1_p1    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            prio_q     <= prio_d;
            vld0_p1    <= gnt0 && !p0_we;
            vld1_p1    <= gnt1 && !p1_we;
        end
    end

    always_comb begin
        mem_en    = gnt0 || gnt1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (gnt0) begin
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
            mem_wmask = p0_wmask;
        end else if (gnt1) begin
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            mem_wmask = p1_wmask;
        end
    end

    assign p0_ready     = gnt0;
    assign p1_ready     = gnt1;
    assign p0_rvalid    = vld0_p1;
    assign p1_rvalid    = vld1_p1;
    assign p0_rdata     = mem_rdata;
    assign p1_rdata     = mem_rdata;
    assign lock_timeout = timeout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios and random traffic checked against a
// transaction-level model of grants, locks, priority and read returns.
module tb_dmem_arbiter;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_LOCK = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p0_valid = 1'b0, p0_we = 1'b0, p0_lock = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic [3:0]  p0_wmask = '0;
    logic        p1_valid = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic [3:0]  p1_wmask = '0;
    logic        p0_ready, p0_rvalid, p1_ready, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_en, mem_we, lock_timeout;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_lock(p0_lock),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_lock(p1_lock),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory driven by the arbiter's memory bus
    logic [31:0] phys [64];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) phys[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= phys[mem_addr[7:2]];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [64];
    int          owner = -1;
    int          age = 0;
    int          pref = 0;
    bit          exp_rv [2];
    logic [31:0] exp_rd [2];
    int          g_now, dut_g;
    bit          to_now, dut_to;
    int          tests = 0;
    int          fails = 0;
    int          pulses, to_at;

    function automatic bit v_of(int p);            return p ? p1_valid : p0_valid; endfunction
    function automatic bit we_of(int p);           return p ? p1_we    : p0_we;    endfunction
    function automatic bit lock_of(int p);         return p ? p1_lock  : p0_lock;  endfunction
    function automatic logic [31:0] addr_of(int p);  return p ? p1_addr  : p0_addr;  endfunction
    function automatic logic [31:0] wdata_of(int p); return p ? p1_wdata : p0_wdata; endfunction
    function automatic logic [3:0]  mask_of(int p);  return p ? p1_wmask : p0_wmask; endfunction

    function automatic int model_grant();
        if (!rst) return -1;
        if (owner >= 0) return v_of(owner) ? owner : -1;
        if (v_of(0) && v_of(1)) return pref;
        if (v_of(0)) return 0;
        if (v_of(1)) return 1;
        return -1;
    endfunction

    task automatic chk(string tag, logic [127:0] act, logic [127:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1; age = 0; pref = 0;
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    endtask

    task automatic check_now(string tag);
        logic [69:0] exp_bus, act_bus;
        g_now  = model_grant();
        to_now = (owner >= 0) && (age == MAX_LOCK);
        dut_g  = p0_ready ? 0 : (p1_ready ? 1 : -1);
        dut_to = lock_timeout;
        exp_bus = '0;
        if (g_now >= 0)
            exp_bus = {1'b1, we_of(g_now), addr_of(g_now), wdata_of(g_now), mask_of(g_now)};
        act_bus = {mem_en, mem_we, mem_addr, mem_wdata, mem_wmask};
        chk({tag, "_ready"}, {p1_ready, p0_ready}, {g_now == 1, g_now == 0});
        chk({tag, "_membus"}, act_bus, exp_bus);
        chk({tag, "_timeout"}, lock_timeout, to_now);
        chk({tag, "_rvalid"}, {p1_rvalid, p0_rvalid}, {exp_rv[1], exp_rv[0]});
        if (exp_rv[0]) chk({tag, "_rdata0"}, p0_rdata, exp_rd[0]);
        if (exp_rv[1]) chk({tag, "_rdata1"}, p1_rdata, exp_rd[1]);
    endtask

    task automatic model_edge();
        int          g;
        bit          to;
        logic [31:0] a, d;
        logic [3:0]  m;
        logic [5:0]  idx;
        g  = g_now;
        to = to_now;
        exp_rv[0] = 1'b0;
        exp_rv[1] = 1'b0;
        if (g >= 0) begin
            a = addr_of(g); d = wdata_of(g); m = mask_of(g);
            idx = a[7:2];
            if (we_of(g)) begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
            end else begin
                exp_rv[g] = 1'b1;
                exp_rd[g] = ref_mem[idx];
            end
        end
`ifdef ARB_ROUND_ROBIN_EN
        if (to) pref = 1 - owner;
        else if (g >= 0) pref = 1 - g;
`else
        if (to) pref = (owner == 0) ? 1 : 0;
        else if (owner < 0 && v_of(0) && v_of(1)) pref = 0;
`endif
        if (owner < 0) begin
            if (g >= 0 && lock_of(g)) begin
                owner = g;
                age = 1;
            end
        end else if (to || (g == owner && !lock_of(g))) begin
            owner = -1;
            age = 0;
        end else begin
            age++;
        end
    endtask

    task automatic cycle(string tag);
        #1;
        check_now(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(int p, bit val, bit we, bit lk, logic [31:0] a, logic [31:0] d, logic [3:0] m);
        if (p == 0) begin
            p0_valid = val; p0_we = we; p0_lock = lk; p0_addr = a; p0_wdata = d; p0_wmask = m;
        end else begin
            p1_valid = val; p1_we = we; p1_lock = lk; p1_addr = a; p1_wdata = d; p1_wmask = m;
        end
    endtask

    task automatic idle(int p);
        drive(p, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        // Reset: requests present but nothing may be granted
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
        drive(1, 1'b1, 1'b1, 1'b1, 32'h14, 32'h1, 4'hF);
        #2;
        check_now("rst_a");
        @(posedge clk);
        @(negedge clk);
        #1;
        check_now("rst_b");
        idle(0); idle(1);
        @(negedge clk);
        rst = 1'b1;

        // Fill memory through port 0, word 4 (0x10) gets 0xDEADBEEF
        for (int i = 0; i < 64; i++) begin
            drive(0, 1'b1, 1'b1, 1'b0, 32'(i * 4), (i == 4) ? 32'hDEADBEEF : $urandom, 4'hF);
            cycle("init");
        end

        // Single read from port 0
        idle(0); idle(1);
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
        cycle("rd10");
        chk("rd10_p0_rvalid", p0_rvalid, 1'b1);
        chk("rd10_p0_rdata", p0_rdata, 32'hDEADBEEF);
        chk("rd10_p1_rvalid", p1_rvalid, 1'b0);
        idle(0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 4'h0);
        cycle("pre_cont");

        // Contention: both ports write for 4 cycles
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b1, 1'b1, 1'b0, 32'h0, $urandom, 4'hF);
            drive(1, 1'b1, 1'b1, 1'b0, 32'h4, $urandom, 4'hF);
            cycle("cont");
`ifdef ARB_ROUND_ROBIN_EN
            chk("cont_winner", dut_g, k % 2);
`else
            chk("cont_winner", dut_g, 0);
`endif
        end
        idle(0); idle(1);
        cycle("cont_end");

        // Locked 3-beat write from port 1 while port 0 waits
        drive(1, 1'b1, 1'b1, 1'b1, 32'h30, $urandom, 4'hF);
        cycle("lk1");
        chk("lk1_g", dut_g, 1);
        drive(0, 1'b1, 1'b1, 1'b0, 32'h40, $urandom, 4'h3);
        drive(1, 1'b1, 1'b1, 1'b1, 32'h34, $urandom, 4'hF);
        cycle("lk2");
        chk("lk2_g", dut_g, 1);
        drive(1, 1'b1, 1'b1, 1'b0, 32'h38, $urandom, 4'hF);
        cycle("lk3");
        chk("lk3_g", dut_g, 1);
        idle(1);
        cycle("lk4");
        chk("lk4_g", dut_g, 0);
        idle(0);
        cycle("lk_end");

        // Lock held until forced release
        drive(1, 1'b1, 1'b1, 1'b1, 32'h20, $urandom, 4'hF);
        cycle("to_enter");
        drive(0, 1'b1, 1'b1, 1'b0, 32'h24, $urandom, 4'hF);
        pulses = 0;
        to_at = -1;
        for (int k = 1; k <= 40 && to_at < 0; k++) begin
            drive(1, 1'b1, 1'b1, 1'b1, 32'h20, $urandom, 4'hF);
            cycle("to_lock");
            if (dut_to) begin
                pulses++;
                to_at = k;
            end
        end
        cycle("to_after");
        if (dut_to) pulses++;
        chk("to_p0_after", dut_g, 0);
        chk("to_at_cnt", to_at, MAX_LOCK);
        chk("to_pulses", pulses, 1);
        idle(0); idle(1);
        cycle("to_end");

        // Reset between read acceptance and the next edge
        drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check_now("rstmid");
        #2;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        idle(0);
        #1;
        chk("rstmid_rvalid", p0_rvalid, 1'b0);
        check_now("rstmid_in");
        rst = 1'b1;
        @(negedge clk);

        // Asynchronous reset clears an active lock
        drive(1, 1'b1, 1'b1, 1'b1, 32'h28, $urandom, 4'hF);
        cycle("rlk_enter");
        rst = 1'b0;
        #1;
        rst = 1'b1;
        model_reset();
        idle(1);
        drive(0, 1'b1, 1'b0, 1'b0, 32'h28, 32'h0, 4'h0);
        cycle("rlk_after");
        chk("rlk_g", dut_g, 0);
        idle(0);
        cycle("rlk_end");

        // Back-to-back reads from port 0
        drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle("b2b_0");
        drive(0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 4'h0);
        chk("b2b_rv0", p0_rvalid, 1'b1);
        chk("b2b_d0", p0_rdata, ref_mem[0]);
        cycle("b2b_1");
        idle(0);
        chk("b2b_rv1", p0_rvalid, 1'b1);
        chk("b2b_d1", p0_rdata, ref_mem[1]);
        cycle("b2b_end");

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            for (int p = 0; p < 2; p++)
                drive(p, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3) == 0, {24'h0, 6'($urandom), 2'b00},
                      $urandom, 4'($urandom));
            cycle("rand");
        end
        idle(0); idle(1);
        cycle("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
